vga_rect_plotter: RTL and testbench
===================================

// Module: vga_rect_plotter
// PURPOSE
//  Parametrised pixel-stream engine driving the vga_adapter plot port (x, y, colour, plot).
//  Accepts rectangle-fill or full-screen-clear commands over a valid/ready handshake.
//  Emits one clipped pixel write per clock in row-major order.
//  Sits between main and the VGA adapter; replaces ad-hoc per-pixel plotting for any resolution/colour depth.
// PARAMETERS
//  SCREEN_W  160  visible columns; pixels with x >= SCREEN_W are never written
//  SCREEN_H  120  visible rows; pixels with y >= SCREEN_H are never written
//  X_W       8    width of x coordinates and widths; must satisfy 2^X_W >= SCREEN_W
//  Y_W       7    width of y coordinates and heights; must satisfy 2^Y_W >= SCREEN_H
//  COLOUR_W  3    colour bits (3 = 1 bit/channel; 3*BITS_PER_COLOUR_CHANNEL in general)
// PORTS
//  clock       in   1         system clock (CLOCK_50)
//  resetn      in   1         asynchronous, active-low reset
//  req_valid   in   1         command present
//  req_ready   out  1         command accepted when req_valid && req_ready
//  req_clear   in   1         1 = clear mode: fill whole screen; ignores req_x/y/w/h
//  req_x       in   X_W       rectangle left column
//  req_y       in   Y_W       rectangle top row
//  req_w       in   X_W       rectangle width in pixels (0 = empty)
//  req_h       in   Y_W       rectangle height in pixels (0 = empty)
//  req_colour  in   COLOUR_W  fill colour
//  vga_x       out  X_W       pixel column to adapter
//  vga_y       out  Y_W       pixel row to adapter
//  vga_colour  out  COLOUR_W  pixel colour to adapter
//  vga_write   out  1         plot strobe; vga_x/y/colour valid when high
//  busy        out  1         high from acceptance until the last pixel is issued
//  done        out  1         one-cycle pulse after command completion
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; vga_x=0, vga_y=0, vga_colour=0, vga_write=0, busy=0, done=0.
//  All outputs are registered. States: IDLE, DRAW.
//  IDLE: req_ready=1. On accept, latch the clipped bounds and colour.
//  - x_end = min(req_x+req_w, SCREEN_W), computed at X_W+1 bits; y_end likewise at Y_W+1.
//  - Clear mode: x0=0, y0=0, x_end=SCREEN_W, y_end=SCREEN_H.
//  - If x0 >= x_end or y0 >= y_end (zero size or fully offscreen): stay IDLE and pulse done next cycle.
//  - Otherwise: go to DRAW with busy=1 and req_ready=0.
//  DRAW: vga_write=1 every cycle. First pixel (x0,y0) appears the cycle after accept (latency 1).
//  - x increments each cycle. At x_end-1, x wraps to x0 and y increments.
//  - After pixel (x_end-1, y_end-1): next cycle vga_write=0, busy=0, done=1, state=IDLE.
//  - Pixel count is exactly (x_end-x0)*(y_end-y0). No gaps and no duplicates.
//  req_ready=0 throughout DRAW. Commands offered while busy are held by the source, not dropped.
//  The cycle done pulses, req_ready=1 again, so back-to-back commands have one idle cycle between them.
//  No offscreen coordinate ever appears with vga_write=1.
//  Asynchronous reset mid-DRAW: vga_write drops immediately; the in-flight command is discarded with no done.
//  req_* inputs are sampled only on the accept cycle; later changes do not affect the command in flight.
// STRUCTURE
//  Package doom58_vga_pkg: default SCREEN_W/H, X_W/Y_W/COLOUR_W, state encoding (IDLE, DRAW).
//  Sub-module vga_clip_bounds (combinational): takes request and mode, returns x0, y0, x_end, y_end, empty.
//  Scan counters and FSM live in vga_rect_plotter.
// TESTING
//  1. Reset, then rect x=10 y=5 w=3 h=2 colour=3'b100.
//     -> 6 writes: (10,5)(11,5)(12,5)(10,6)(11,6)(12,6); done 1 cycle after (12,6).
//  2. Clear, colour=0, default params.
//     -> 19200 writes covering (0,0)..(159,119) exactly once; busy high for 19200 cycles.
//  3. Clipping: rect x=158 y=118 w=5 h=5.
//     -> 4 writes (158,118)(159,118)(158,119)(159,119); x=170 w=4 -> no writes, done next cycle.
//  4. w=0 h=7 -> zero writes, done pulses 1 cycle after accept, req_ready stays 1.
//  5. Second command held valid during DRAW -> not accepted until the done cycle; first pixel 1 cycle later.
//  6. resetn low for 1 cycle mid-clear -> vga_write=0 immediately, busy=0, no done; next rect draws correctly.

Source files
------------

// File: rtl/doom58_vga_pkg.sv
// Shared defaults and state encoding for the VGA rectangle plotter.
//   SCREEN_W/H_DEF : visible resolution
//   X_W/Y_W_DEF    : coordinate widths (2^X_W >= SCREEN_W, 2^Y_W >= SCREEN_H)
//   COLOUR_W_DEF   : colour bits per pixel
package doom58_vga_pkg;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int X_W_DEF      = 8;
  localparam int Y_W_DEF      = 7;
  localparam int COLOUR_W_DEF = 3;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_e;
endpackage

// File: rtl/vga_clip_bounds.sv
// Combinational clipper: turns a rectangle request (or clear) into
// on-screen scan bounds.
//   i_clear        : 1 = whole screen, ignore x/y/w/h
//   i_x/i_y/i_w/i_h: rectangle origin and size
//   o_x0/o_y0      : first column / row
//   o_x_end/o_y_end: one past last column / row (one bit wider than coords)
//   o_empty        : nothing on screen to draw
module vga_clip_bounds
  import doom58_vga_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF
) (
  input  logic         i_clear,
  input  logic [X_W-1:0] i_x,
  input  logic [Y_W-1:0] i_y,
  input  logic [X_W-1:0] i_w,
  input  logic [Y_W-1:0] i_h,
  output logic [X_W-1:0] o_x0,
  output logic [Y_W-1:0] o_y0,
  output logic [X_W:0]   o_x_end,
  output logic [Y_W:0]   o_y_end,
  output logic           o_empty
);
  localparam logic [X_W:0] XLIM = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] YLIM = (Y_W+1)'(SCREEN_H);

  // Sums carry an extra bit so x+w never wraps back onto the screen.
  logic [X_W:0] w_x_sum;
  logic [Y_W:0] w_y_sum;

  always_comb begin
    w_x_sum = {1'b0, i_x} + {1'b0, i_w};
    w_y_sum = {1'b0, i_y} + {1'b0, i_h};
    if (i_clear) begin
      o_x0    = '0;
      o_y0    = '0;
      o_x_end = XLIM;
      o_y_end = YLIM;
    end else begin
      o_x0    = i_x;
      o_y0    = i_y;
      o_x_end = (w_x_sum > XLIM) ? XLIM : w_x_sum;
      o_y_end = (w_y_sum > YLIM) ? YLIM : w_y_sum;
    end
  end

  // Covers zero width/height and origins that start past the screen edge.
  assign o_empty = ({1'b0, o_x0} >= o_x_end) || ({1'b0, o_y0} >= o_y_end);
endmodule

// File: rtl/vga_rect_plotter.sv
// Pixel-stream engine for the vga_adapter plot port. Accepts a rectangle
// fill or full-screen clear over valid/ready and emits one clipped pixel
// per clock in row-major order.
//   clock, resetn            : clock, async active-low reset
//   req_valid/req_ready      : command handshake
//   req_clear                : clear mode (whole screen)
//   req_x/y/w/h, req_colour  : rectangle and fill colour
//   vga_x/y/colour/write     : adapter plot port (registered)
//   busy                     : drawing in progress
//   done                     : one-cycle completion pulse
module vga_rect_plotter
  import doom58_vga_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int COLOUR_W = COLOUR_W_DEF
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_clear,
  input  logic [X_W-1:0]      req_x,
  input  logic [Y_W-1:0]      req_y,
  input  logic [X_W-1:0]      req_w,
  input  logic [Y_W-1:0]      req_h,
  input  logic [COLOUR_W-1:0] req_colour,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_write,
  output logic                busy,
  output logic                done
);
  logic [X_W-1:0] w_x0;
  logic [Y_W-1:0] w_y0;
  logic [X_W:0]   w_x_end;
  logic [Y_W:0]   w_y_end;
  logic           w_empty;

  vga_clip_bounds #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_clip (
    .i_clear (req_clear),
    .i_x     (req_x),
    .i_y     (req_y),
    .i_w     (req_w),
    .i_h     (req_h),
    .o_x0    (w_x0),
    .o_y0    (w_y0),
    .o_x_end (w_x_end),
    .o_y_end (w_y_end),
    .o_empty (w_empty)
  );

  state_e                r_state, w_state_nxt;
  logic [X_W-1:0]        r_x0, w_x0_nxt;
  // Store last column/row rather than end, so wrap tests are plain equality
  // against the output coordinate registers.
  logic [X_W-1:0]        r_xlast, w_xlast_nxt;
  logic [Y_W-1:0]        r_ylast, w_ylast_nxt;
  logic [X_W-1:0]        r_vga_x, w_vga_x_nxt;
  logic [Y_W-1:0]        r_vga_y, w_vga_y_nxt;
  logic [COLOUR_W-1:0]   r_vga_colour, w_vga_colour_nxt;
  logic                  r_vga_write, w_vga_write_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_ready, w_ready_nxt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_x0         <= '0;
      r_xlast      <= '0;
      r_ylast      <= '0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_write  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ready      <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_x0         <= w_x0_nxt;
      r_xlast      <= w_xlast_nxt;
      r_ylast      <= w_ylast_nxt;
      r_vga_x      <= w_vga_x_nxt;
      r_vga_y      <= w_vga_y_nxt;
      r_vga_colour <= w_vga_colour_nxt;
      r_vga_write  <= w_vga_write_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_ready      <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_x0_nxt         = r_x0;
    w_xlast_nxt      = r_xlast;
    w_ylast_nxt      = r_ylast;
    w_vga_x_nxt      = r_vga_x;
    w_vga_y_nxt      = r_vga_y;
    w_vga_colour_nxt = r_vga_colour;
    w_vga_write_nxt  = r_vga_write;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_ready_nxt      = r_ready;

    unique case (r_state)
      IDLE: begin
        w_vga_write_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_ready_nxt     = 1'b1;
        if (req_valid && r_ready) begin
          if (w_empty) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt      = DRAW;
            w_x0_nxt         = w_x0;
            w_xlast_nxt      = X_W'(w_x_end - (X_W+1)'(1));
            w_ylast_nxt      = Y_W'(w_y_end - (Y_W+1)'(1));
            w_vga_x_nxt      = w_x0;
            w_vga_y_nxt      = w_y0;
            w_vga_colour_nxt = req_colour;
            w_vga_write_nxt  = 1'b1;
            w_busy_nxt       = 1'b1;
            w_ready_nxt      = 1'b0;
          end
        end
      end
      DRAW: begin
        // The output registers hold the pixel being written this cycle;
        // decide what the next one is.
        if (r_vga_x == r_xlast) begin
          if (r_vga_y == r_ylast) begin
            w_state_nxt     = IDLE;
            w_vga_write_nxt = 1'b0;
            w_busy_nxt      = 1'b0;
            w_done_nxt      = 1'b1;
            w_ready_nxt     = 1'b1;
          end else begin
            w_vga_x_nxt = r_x0;
            w_vga_y_nxt = r_vga_y + Y_W'(1);
          end
        end else begin
          w_vga_x_nxt = r_vga_x + X_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign req_ready  = r_ready;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_write  = r_vga_write;
  assign busy       = r_busy;
  assign done       = r_done;
endmodule

// File: tb/tb_vga_rect_plotter.sv
module tb_vga_rect_plotter;
  logic       clock;
  logic       resetn;
  logic       req_valid;
  logic       req_ready;
  logic       req_clear;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [7:0] req_w;
  logic [6:0] req_h;
  logic [2:0] req_colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_write;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  vga_rect_plotter dut (
    .clock      (clock),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_clear  (req_clear),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_write  (vga_write),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Send one command and follow the pixel stream against hand-derived
  // bounds [ex0,exe) x [ey0,eye).
  task automatic draw_check(input string tag, input logic clr,
                            input int x, input int y, input int w, input int h, input int col,
                            input int ex0, input int ey0, input int exe, input int eye);
    int n, bad, cx, cy, exp_n;
    exp_n = (exe > ex0 && eye > ey0) ? (exe - ex0) * (eye - ey0) : 0;
    req_clear  = clr;
    req_x      = 8'(x);
    req_y      = 7'(y);
    req_w      = 8'(w);
    req_h      = 7'(h);
    req_colour = 3'(col);
    req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
    n = 0; bad = 0; cx = ex0; cy = ey0;
    while (vga_write && n < exp_n + 4) begin
      if (vga_x !== 8'(cx) || vga_y !== 7'(cy) || vga_colour !== 3'(col) ||
          busy !== 1'b1 || req_ready !== 1'b0)
        bad++;
      n++;
      cx++;
      if (cx == exe) begin cx = ex0; cy++; end
      tick();
    end
    chk({tag, " count"},  n, exp_n);
    chk({tag, " pixels"}, bad, 0);
    chk({tag, " write0"}, vga_write, 0);
    chk({tag, " done"},   done, 1);
    chk({tag, " busy0"},  busy, 0);
    chk({tag, " ready"},  req_ready, 1);
    tick();
    chk({tag, " done1cyc"}, done, 0);
  endtask

  initial begin
    int bad;
    req_valid = 0; req_clear = 0; req_x = 0; req_y = 0;
    req_w = 0; req_h = 0; req_colour = 0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1;
    chk("rst ready", req_ready, 1);
    chk("rst write", vga_write, 0);
    chk("rst busy",  busy, 0);
    chk("rst done",  done, 0);
    chk("rst xy",    {vga_x, vga_y}, 0);
    chk("rst colour", vga_colour, 0);
    tick();
    resetn = 1'b1;
    tick();

    draw_check("rect",   0, 10, 5, 3, 2, 4, 10, 5, 13, 7);
    draw_check("clear",  1, 55, 66, 0, 0, 0, 0, 0, 160, 120);
    draw_check("clip",   0, 158, 118, 5, 5, 7, 158, 118, 160, 120);
    draw_check("offscr", 0, 170, 0, 4, 1, 1, 170, 0, 160, 1);
    draw_check("w0",     0, 20, 20, 0, 7, 3, 20, 20, 20, 27);

    // Second command held valid during a draw.
    req_clear = 0; req_x = 0; req_y = 0; req_w = 2; req_h = 2; req_colour = 5;
    req_valid = 1'b1;
    tick();
    req_x = 20; req_y = 30; req_w = 1; req_h = 1; req_colour = 2;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (vga_write !== 1'b1 || req_ready !== 1'b0 || vga_x !== 8'(i % 2) ||
          vga_y !== 7'(i / 2) || vga_colour !== 3'd5)
        bad++;
      tick();
    end
    chk("hold pixels", bad, 0);
    chk("hold done",   done, 1);
    chk("hold ready",  req_ready, 1);
    chk("hold write0", vga_write, 0);
    tick();
    chk("b write",  vga_write, 1);
    chk("b xy",     {vga_x, vga_y}, {8'd20, 7'd30});
    chk("b colour", vga_colour, 2);
    chk("b busy",   busy, 1);
    req_valid = 1'b0;
    tick();
    chk("b end write", vga_write, 0);
    chk("b end done",  done, 1);
    tick();

    // Reset in the middle of a clear.
    req_clear = 1; req_colour = 1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; req_clear = 0;
    repeat (40) tick();
    chk("mid write", vga_write, 1);
    resetn = 1'b0;
    #1;
    chk("arst write", vga_write, 0);
    chk("arst busy",  busy, 0);
    chk("arst ready", req_ready, 1);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    chk("arst done a", done, 0);
    tick();
    chk("arst done b", done, 0);
    chk("arst write b", vga_write, 0);
    draw_check("post", 0, 3, 4, 2, 1, 6, 3, 4, 5, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
